// File: rtl/hdb3_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hdb3_decode
// Description : HDB3 line decoder. Detects bipolar violations, removes the
//               V pulse and its paired B pulse, restores the NRZ bit stream
//               and flags line-code errors with a pulse and saturating count.
// Revision    : 1.0 - initial release
// ============================================================================
module hdb3_decode #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_hdb3_code,
    output logic                 o_data,
    output logic                 o_valid,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};

    logic [3:0]           r_d;
    logic [3:0]           r_vld;
    logic                 r_have_pol;
    logic                 r_last_pol;
    logic                 r_have_vpol;
    logic                 r_last_vpol;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic w_mark;
    logic w_pol;
    logic w_illegal;
    logic w_viol;
    logic w_err_order;
    logic w_err_alt;

    assign w_mark      = (i_hdb3_code == 2'b01) || (i_hdb3_code == 2'b10);
    assign w_pol       = (i_hdb3_code == 2'b10);
    assign w_illegal   = (i_hdb3_code == 2'b11);
    assign w_viol      = w_mark && r_have_pol && (w_pol == r_last_pol);
    // A V must follow two zeros, and successive V pulses must alternate.
    assign w_err_order = w_viol && (r_d[0] || r_d[1]);
    assign w_err_alt   = w_viol && r_have_vpol && (w_pol == r_last_vpol);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d         <= 4'b0000;
            r_vld       <= 4'b0000;
            r_have_pol  <= 1'b0;
            r_last_pol  <= 1'b0;
            r_have_vpol <= 1'b0;
            r_last_vpol <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            // d[3] stage drops the B pulse that sits three symbols ahead of V.
            r_d[0] <= w_mark && !w_viol;
            r_d[1] <= r_d[0];
            r_d[2] <= r_d[1];
            r_d[3] <= r_d[2] && !w_viol;
            r_vld  <= {r_vld[2:0], 1'b1};
            if (w_mark) begin
                r_have_pol <= 1'b1;
                r_last_pol <= w_pol;
            end
            if (w_viol) begin
                r_have_vpol <= 1'b1;
                r_last_vpol <= w_pol;
            end
            r_err <= w_illegal || w_err_order || w_err_alt;
            if (r_err && (r_err_cnt != c_err_max)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign o_data    = r_d[3];
    assign o_valid   = r_vld[3];
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hdb3_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hdb3_decode
// Description : Bench for hdb3_decode with a history-based reference model,
//               an HDB3 source encoder for loopback and directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdb3_decode;

    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] code;
    logic       data, valid, err;
    logic [7:0] cnt;
    logic       data2, valid2, err2;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    hdb3_decode dut (
        .i_clk(clk), .i_rst(rst), .i_hdb3_code(code),
        .o_data(data), .o_valid(valid), .o_err(err), .o_err_cnt(cnt)
    );

    hdb3_decode #(.ERR_CNT_W(2)) dut_w2 (
        .i_clk(clk), .i_rst(rst), .i_hdb3_code(code),
        .o_data(data2), .o_valid(valid2), .o_err(err2), .o_err_cnt(cnt2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: symbol history since reset, decoded from the line rules.
    int  n;
    bit  mk[8];
    bit  m_hp, m_lp, m_hvp, m_lvp;
    bit  e_data, e_valid, e_err;
    int  e_cnt, e_cnt2;
    bit  s_m, s_p, s_v, s_ill, s_eb, s_ec;
    bit  cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            foreach (mk[i]) mk[i] = 1'b0;
            m_hp = 0; m_lp = 0; m_hvp = 0; m_lvp = 0;
            e_data = 0; e_valid = 0; e_err = 0; e_cnt = 0; e_cnt2 = 0;
        end else begin
            s_ill = (code == X);
            s_m   = (code == P) || (code == N);
            s_p   = (code == N);
            s_v   = s_m && m_hp && (s_p == m_lp);
            if (e_err) begin
                if (e_cnt < 255) e_cnt++;
                if (e_cnt2 < 3) e_cnt2++;
            end
            n++;
            s_eb  = s_v && ((n >= 2 && mk[(n-1)%8]) || (n >= 3 && mk[(n-2)%8]));
            s_ec  = s_v && m_hvp && (s_p == m_lvp);
            e_err = s_ill || s_eb || s_ec;
            mk[n%8] = s_m && !s_v;
            e_data  = (n >= 4) && mk[(n-3)%8] && !s_v;
            e_valid = (n >= 4);
            if (s_m) begin m_hp = 1; m_lp = s_p; end
            if (s_v) begin m_hvp = 1; m_lvp = s_p; end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_data",  data,  e_data);
            check("model_valid", valid, e_valid);
            check("model_err",   err,   e_err);
            check("model_cnt",   cnt,   e_cnt);
            check("model_data2", data2, e_data);
            check("model_cnt2",  cnt2,  e_cnt2);
        end
    end

    task automatic send(input logic [1:0] s);
        code = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst  = 1'b1;
        code = Z;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
    endtask

    // HDB3 source encoder used to build loopback streams.
    bit         src_q[$];
    logic [1:0] sym_q[$];

    function automatic logic [1:0] pulse(input bit neg);
        return neg ? N : P;
    endfunction

    task automatic encode();
        bit last_neg;
        int ones;
        int i;
        last_neg = 1'b1;
        ones = 0;
        i = 0;
        sym_q.delete();
        while (i < src_q.size()) begin
            if (i + 3 < src_q.size() && !src_q[i] && !src_q[i+1] && !src_q[i+2] && !src_q[i+3]) begin
                if (ones % 2 == 1) begin
                    sym_q.push_back(Z); sym_q.push_back(Z); sym_q.push_back(Z);
                    sym_q.push_back(pulse(last_neg));
                end else begin
                    last_neg = !last_neg;
                    sym_q.push_back(pulse(last_neg)); sym_q.push_back(Z);
                    sym_q.push_back(Z); sym_q.push_back(pulse(last_neg));
                end
                ones = 0;
                i += 4;
            end else if (src_q[i]) begin
                last_neg = !last_neg;
                sym_q.push_back(pulse(last_neg));
                ones++;
                i++;
            end else begin
                sym_q.push_back(Z);
                i++;
            end
        end
    endtask

    task automatic run_loopback(input string name);
        do_reset(1);
        encode();
        for (int k = 0; k < sym_q.size(); k++) begin
            send(sym_q[k]);
            if (k >= 3) check(name, data, src_q[k-3]);
        end
    endtask

    initial begin
        bit pat[11];
        rst  = 1'b1;
        code = Z;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_cnt", cnt, 0);
        rst = 1'b0;

        // 000V then B00V
        send(P); check("v0_valid_e1", valid, 0);
        send(Z); send(Z); check("v0_valid_e3", valid, 0);
        send(Z); check("v0_valid_e4", valid, 1); check("v0_data_e4", data, 1);
        send(P); check("v0_data_e5", data, 0); check("v0_err_e5", err, 0);
        send(N); check("b00v_data_e6", data, 0);
        send(Z); check("b00v_data_e7", data, 0);
        send(Z); check("b00v_data_e8", data, 0);
        send(N); check("b00v_data_e9", data, 0); check("b00v_err", err, 0);
        send(Z); check("b00v_cnt", cnt, 0);

        // Illegal symbol injection
        send(X); check("ill_err", err, 1);
        send(Z); check("ill_err_end", err, 0); check("ill_cnt", cnt, 1);
        send(Z); check("ill_decode", data, 0);

        // V without preceding zeros, then two same-polarity V pulses
        do_reset(1);
        send(P); send(P); check("vord_err", err, 1);
        send(Z); check("vord_err_end", err, 0); check("vord_cnt", cnt, 1);
        send(Z); send(Z);
        send(P); check("valt_err", err, 1);
        send(Z); check("valt_cnt", cnt, 2);

        // Saturation of the narrow counter
        do_reset(1);
        repeat (5) begin send(X); send(Z); end
        send(Z);
        check("sat_cnt2", cnt2, 3);
        check("sat_cnt", cnt, 5);

        // Mid-stream reset
        send(P); send(Z); send(N); send(P);
        rst = 1'b1; code = P;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("mrst_data", data, 0);
        check("mrst_valid", valid, 0);
        check("mrst_err", err, 0);
        check("mrst_cnt", cnt, 0);
        send(P); send(Z); send(Z); check("mrst_valid_e3", valid, 0);
        send(Z); check("mrst_valid_e4", valid, 1); check("mrst_first_mark", data, 1);

        // Loopback of the repeating pattern
        pat = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        src_q.delete();
        for (int r = 0; r < 92; r++)
            for (int j = 0; j < 11; j++) src_q.push_back(pat[j]);
        run_loopback("loop_pat");
        check("loop_pat_cnt", cnt, 0);

        // Loopback of random data, sparse ones to exercise substitutions
        src_q.delete();
        for (int j = 0; j < 600; j++) src_q.push_back($urandom_range(0, 2) == 0);
        run_loopback("loop_rand");
        check("loop_rand_cnt", cnt, 0);

        // Raw random symbols with occasional resets, model-checked
        for (int j = 0; j < 800; j++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                send(2'($urandom_range(0, 3)));
                rst = 1'b0;
            end else begin
                send(2'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hdb3_decode.md
Name: hdb3_decode

Overview:
- HDB3 decoder; the receive-side stage that sits directly downstream of hdb3_code.
- Consumes the 2-bit ternary symbol stream hdb3_code produces, one symbol per clock.
- Detects bipolar violations, strips the V pulse and its paired B pulse, and restores the original unipolar NRZ bit stream.
- Flags line-code errors with a pulse output and a saturating counter; used in loopback benches and on the receive path.

Parameters:
- ERR_CNT_W, 8, width of the saturating line-code error counter.

Ports:
- i_clk  input  1  system clock; one HDB3 symbol per rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_hdb3_code  input  2  symbol: 2'b00 = zero, 2'b01 = +1, 2'b10 = -1, 2'b11 = illegal.
- o_data  output  1  decoded NRZ bit.
- o_valid  output  1  high once o_data carries a decoded symbol.
- o_err  output  1  one-cycle pulse per detected line-code error.
- o_err_cnt  output  ERR_CNT_W  saturating count of o_err pulses.

Behaviour:
- Clocking and reset: one clock, reset synchronous active-high; everything updates on the rising edge of i_clk.
- While i_rst is high at an edge, these all clear to 0: o_data, o_valid, o_err, o_err_cnt, the delay line d[3:0], the valid line vld[3:0], have_pol, last_pol, have_vpol, last_vpol.
- mark = (code == 01) or (code == 10).
- pol = (code == 10), i.e. 1 means negative.
- 2'b11 is treated as a zero symbol (mark = 0) and raises an error.
- Violation: v = mark and have_pol and (pol == last_pol).
- The first mark after reset is never a violation.
- Delay line, per non-reset edge:
  - d[0] <= mark and not v
  - d[1] <= d[0]
  - d[2] <= d[1]
  - d[3] <= d[2] and not v. This clears the B pulse, which is the symbol sampled 3 edges before V. In a 000V pattern d[2] is already 0.
- o_data = d[3].
- Latency: symbol sampled at edge k appears on o_data after edge k+3.
- vld shifts in 1 each edge; o_valid = vld[3]. First high after the 4th post-reset edge, then stays high.
- Polarity tracking:
  - On every mark (B, V or data), last_pol <= pol and have_pol <= 1.
  - On v, last_vpol <= pol and have_vpol <= 1.
- Error conditions, registered; o_err is high the edge after detection. More than one condition in the same cycle gives a single pulse.
  - (a) code == 11.
  - (b) v while d[0] or d[1] is set: a V must be preceded by two zeros.
  - (c) v while have_vpol and pol == last_vpol: successive V pulses must alternate.
- Error handling: the decoded stream continues unchanged; the decoder does not resynchronise.
- o_err_cnt increments on each o_err pulse and saturates at 2^ERR_CNT_W - 1; it is not cleared except by reset.
- Reset mid-stream: the pipeline flushes to 0 and polarity history is lost. The next mark is accepted as data, even if the encoder intended it as a V.
- Consecutive V detections 4 symbols apart (the all-zeros input case) must decode to continuous 0s with no error.

Test Plan:
- Reset, then symbols +,0,0,0,+ (000V) -> o_data sequence 1,0,0,0,0 starting after the 4th edge; o_err stays 0; o_valid rises after the 4th edge.
- Continue with -,0,0,- (B00V after a positive V) -> 0,0,0,0 on o_data; the B pulse is cleared from d[3]; no error.
- Loopback: pluse -> hdb3_code -> hdb3_decode with 1,1,0,0,0,0,0,0,0,0,1 repeated -> o_data equals the source delayed by the combined encoder and decoder latency; o_err_cnt stays 0 for 1000 cycles.
- Inject 2'b11 mid-stream -> exactly one o_err pulse; o_err_cnt increments by 1; that symbol decodes as 0.
- Inject +,+,0,0 after reset (V not preceded by 00) -> o_err pulses once; two same-polarity V pulses in a row -> a second pulse.
- ERR_CNT_W = 2 with 5 injected 2'b11 symbols -> o_err_cnt saturates at 3.
- Assert i_rst for one edge mid-stream -> all outputs are 0 after that edge; o_valid returns 4 edges later.
